// File: rtl/timestamp_hdr_insert.sv
// -----------------------------------------------------------------------------
// timestamp_hdr_insert
//
// Purpose:
//   Sits between the timestamping input arbiter and the output port lookup.
//   Each packet from the arbiter gets one extra module-header word prepended:
//   {TS_CTRL, arrival timestamp}. Timestamps are queued in their own FIFO and
//   paired with packets in arrival order. A packet with no pending timestamp
//   either passes through unchanged (STAMP_MISSING=0) or gets an all-zero
//   timestamp word (STAMP_MISSING=1).
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   in_data/in_ctrl     - packet word and ctrl from the arbiter
//   in_wr / in_rdy      - input word strobe / room in the word FIFO
//   in_timestamp        - 64-bit arrival time
//   in_timestamp_valid  - one-cycle pulse that queues in_timestamp
//   out_data/out_ctrl   - registered word to the next stage
//   out_wr / out_rdy    - registered output strobe / downstream ready
//   stamped_pkts        - wrapping count of packets given a timestamp word
//   ts_overflow         - sticky, a timestamp was dropped on a full TS FIFO
// -----------------------------------------------------------------------------
module timestamp_hdr_insert #(
  parameter int                    DATA_WIDTH         = 64,
  parameter int                    CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] TS_CTRL            = 8'hEE,
  parameter int                    TS_FIFO_DEPTH_BITS = 3,
  parameter bit                    STAMP_MISSING      = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  input  logic [63:0]           in_timestamp,
  input  logic                  in_timestamp_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           stamped_pkts,
  output logic                  ts_overflow
);

  localparam int                            WF_W        = DATA_WIDTH + CTRL_WIDTH;
  localparam int                            TS_DEPTH    = 1 << TS_FIFO_DEPTH_BITS;
  localparam logic [TS_FIFO_DEPTH_BITS:0]   TS_FULL_CNT = {1'b1, {TS_FIFO_DEPTH_BITS{1'b0}}};
  localparam logic [TS_FIFO_DEPTH_BITS-1:0] TS_PTR_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;

  // ---------------------------------------------------------------------------
  // Stage p0: word FIFO (4 deep) and timestamp FIFO, fall-through heads
  // ---------------------------------------------------------------------------
  logic [WF_W-1:0]               r_wf_mem [4];
  logic [1:0]                    r_wf_wptr, r_wf_rptr;
  logic [2:0]                    r_wf_cnt;
  logic [63:0]                   r_ts_mem [TS_DEPTH];
  logic [TS_FIFO_DEPTH_BITS-1:0] r_ts_wptr, r_ts_rptr;
  logic [TS_FIFO_DEPTH_BITS:0]   r_ts_cnt;

  logic                  w_wf_push, w_wf_pop, w_wf_nempty;
  logic                  w_ts_push, w_ts_pop, w_ts_nempty, w_ts_drop;
  logic [WF_W-1:0]       w_wf_head;
  logic [CTRL_WIDTH-1:0] w_head_ctrl;
  logic [DATA_WIDTH-1:0] w_head_data;

  assign w_wf_nempty = (r_wf_cnt != 3'd0);
  assign w_ts_nempty = (r_ts_cnt != '0);
  // A write into a full FIFO is still accepted when a pop frees a slot.
  assign w_wf_push   = in_wr && ((r_wf_cnt != 3'd4) || w_wf_pop);
  assign w_ts_push   = in_timestamp_valid && ((r_ts_cnt != TS_FULL_CNT) || w_ts_pop);
  assign w_ts_drop   = in_timestamp_valid && (r_ts_cnt == TS_FULL_CNT) && !w_ts_pop;
  // Nearly full at 3 of 4 leaves one slot for a word already in flight.
  assign in_rdy      = (r_wf_cnt < 3'd3);
  assign w_wf_head   = r_wf_mem[r_wf_rptr];
  assign w_head_ctrl = w_wf_head[WF_W-1 -: CTRL_WIDTH];
  assign w_head_data = w_wf_head[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (w_wf_push) r_wf_mem[r_wf_wptr] <= {in_ctrl, in_data};
    if (w_ts_push) r_ts_mem[r_ts_wptr] <= in_timestamp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wf_wptr <= '0;
      r_wf_rptr <= '0;
      r_wf_cnt  <= '0;
      r_ts_wptr <= '0;
      r_ts_rptr <= '0;
      r_ts_cnt  <= '0;
    end else begin
      if (w_wf_push) r_wf_wptr <= r_wf_wptr + 2'd1;
      if (w_wf_pop)  r_wf_rptr <= r_wf_rptr + 2'd1;
      r_wf_cnt <= r_wf_cnt + {2'b00, w_wf_push} - {2'b00, w_wf_pop};
      if (w_ts_push) r_ts_wptr <= r_ts_wptr + TS_PTR_ONE;
      if (w_ts_pop)  r_ts_rptr <= r_ts_rptr + TS_PTR_ONE;
      r_ts_cnt <= r_ts_cnt + {{TS_FIFO_DEPTH_BITS{1'b0}}, w_ts_push}
                           - {{TS_FIFO_DEPTH_BITS{1'b0}}, w_ts_pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: framing FSM selects the next output word
  // ---------------------------------------------------------------------------
  state_t                r_state, w_state_next;
  logic                  w_out_wr_next, w_stamp;
  logic [CTRL_WIDTH-1:0] w_out_ctrl_next;
  logic [DATA_WIDTH-1:0] w_out_data_next;

  always_comb begin
    w_state_next    = r_state;
    w_wf_pop        = 1'b0;
    w_ts_pop        = 1'b0;
    w_stamp         = 1'b0;
    w_out_wr_next   = 1'b0;
    w_out_ctrl_next = '0;
    w_out_data_next = '0;
    if (w_wf_nempty && out_rdy) begin
      case (r_state)
        S_IDLE: begin
          // The packet's first word stays queued; only the stamp goes out.
          w_state_next = S_HDR;
          if (w_ts_nempty) begin
            w_ts_pop        = 1'b1;
            w_stamp         = 1'b1;
            w_out_wr_next   = 1'b1;
            w_out_ctrl_next = TS_CTRL;
            w_out_data_next = r_ts_mem[r_ts_rptr];
          end else if (STAMP_MISSING) begin
            w_stamp         = 1'b1;
            w_out_wr_next   = 1'b1;
            w_out_ctrl_next = TS_CTRL;
          end
        end
        S_HDR: begin
          w_wf_pop        = 1'b1;
          w_out_wr_next   = 1'b1;
          w_out_ctrl_next = w_head_ctrl;
          w_out_data_next = w_head_data;
          if (w_head_ctrl == '0) w_state_next = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          w_wf_pop        = 1'b1;
          w_out_wr_next   = 1'b1;
          w_out_ctrl_next = w_head_ctrl;
          w_out_data_next = w_head_data;
          // First non-zero ctrl after payload marks end of packet.
          if (w_head_ctrl != '0) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered output, counter and sticky overflow flag
  // ---------------------------------------------------------------------------
  logic                  r_out_wr;
  logic [CTRL_WIDTH-1:0] r_out_ctrl;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [31:0]           r_stamped;
  logic                  r_ts_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_out_wr   <= 1'b0;
      r_out_ctrl <= '0;
      r_out_data <= '0;
      r_stamped  <= '0;
      r_ts_ovf   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_out_wr <= w_out_wr_next;
      if (w_out_wr_next) begin
        r_out_ctrl <= w_out_ctrl_next;
        r_out_data <= w_out_data_next;
      end
      if (w_stamp)   r_stamped <= r_stamped + 32'd1;
      if (w_ts_drop) r_ts_ovf  <= 1'b1;
    end
  end

  assign out_wr       = r_out_wr;
  assign out_ctrl     = r_out_ctrl;
  assign out_data     = r_out_data;
  assign stamped_pkts = r_stamped;
  assign ts_overflow  = r_ts_ovf;

endmodule

// File: tb/tb_timestamp_hdr_insert.sv
`timescale 1ns/1ps
module tb_timestamp_hdr_insert;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_wr, in_ts_valid, out_rdy;
  logic [63:0] in_data, in_ts;
  logic [7:0]  in_ctrl;
  logic        in_rdy0, in_rdy1, out_wr0, out_wr1, ovf0, ovf1;
  logic [63:0] out_data0, out_data1;
  logic [7:0]  out_ctrl0, out_ctrl1;
  logic [31:0] st0, st1;

  timestamp_hdr_insert #(.STAMP_MISSING(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy0), .in_timestamp(in_ts), .in_timestamp_valid(in_ts_valid),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .out_wr(out_wr0), .out_rdy(out_rdy),
    .stamped_pkts(st0), .ts_overflow(ovf0));

  timestamp_hdr_insert #(.STAMP_MISSING(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy1), .in_timestamp(in_ts), .in_timestamp_valid(in_ts_valid),
    .out_data(out_data1), .out_ctrl(out_ctrl1), .out_wr(out_wr1), .out_rdy(out_rdy),
    .stamped_pkts(st1), .ts_overflow(ovf1));

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int sop_cyc = 0;
  int last_wr_cyc = 0;
  logic [71:0] q0[$], q1[$];
  int qc0[$], qc1[$];
  logic last_rdy;
  bit toggle_en = 1'b0;
  bit saw_full = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_rdy <= out_rdy;
  end

  // Output capture plus the hold-off rule after a sampled out_rdy=0.
  always @(negedge clk) begin
    if (out_wr0 === 1'b1) begin q0.push_back({out_ctrl0, out_data0}); qc0.push_back(cyc); end
    if (out_wr1 === 1'b1) begin q1.push_back({out_ctrl1, out_data1}); qc1.push_back(cyc); end
    if (in_rdy0 === 1'b0) saw_full = 1'b1;
    if (last_rdy === 1'b0) begin
      compared++;
      assert (out_wr0 === 1'b0 && out_wr1 === 1'b0) else begin
        mismatched++;
        $error("FAIL bp_hold: out_wr0=%b out_wr1=%b required 0", out_wr0, out_wr1);
      end
    end
    if (toggle_en) out_rdy = ~out_rdy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] qget(input int which, input int pos);
    if (which == 0) return (pos < q0.size()) ? q0[pos] : {72{1'bx}};
    return (pos < q1.size()) ? q1[pos] : {72{1'bx}};
  endfunction

  function automatic int first_cyc(input int which);
    if (which == 0) return (qc0.size() > 0) ? qc0[0] : -1;
    return (qc1.size() > 0) ? qc1[0] : -1;
  endfunction

  task automatic chk_pkt(input string tag, input int which, inout int pos, input bit has_ts,
                         input logic [63:0] ts, input int n_pay, input logic [7:0] eopc,
                         input logic [63:0] base);
    if (has_ts) begin chk({tag, "_ts"}, qget(which, pos), {8'hEE, ts}); pos++; end
    chk({tag, "_hdr"}, qget(which, pos), {8'hFF, base}); pos++;
    for (int i = 1; i <= n_pay; i++) begin
      chk($sformatf("%s_pay%0d", tag, i), qget(which, pos), {8'h00, base + 64'(i)}); pos++;
    end
    chk({tag, "_eop"}, qget(which, pos), {eopc, base + 64'(n_pay + 1)}); pos++;
  endtask

  task automatic send_word(input logic [7:0] c, input logic [63:0] d);
    int guard = 0;
    @(negedge clk);
    while (!(in_rdy0 && in_rdy1) && guard < 500) begin
      in_wr = 1'b0; guard++; @(negedge clk);
    end
    if (guard >= 500) chk("in_rdy_timeout", 72'(guard), 72'd0);
    in_ctrl = c; in_data = d; in_wr = 1'b1; last_wr_cyc = cyc;
  endtask

  task automatic end_burst();
    @(negedge clk); in_wr = 1'b0;
  endtask

  task automatic send_pkt(input int n_pay, input logic [7:0] eopc, input logic [63:0] base);
    send_word(8'hFF, base);
    sop_cyc = last_wr_cyc;
    for (int i = 1; i <= n_pay; i++) send_word(8'h00, base + 64'(i));
    send_word(eopc, base + 64'(n_pay + 1));
  endtask

  task automatic push_ts(input logic [63:0] v);
    @(negedge clk); in_ts = v; in_ts_valid = 1'b1;
    @(negedge clk); in_ts_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; in_wr = 1'b0; in_ts_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q0.delete(); q1.delete(); qc0.delete(); qc1.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pos;
    int g;
    reset = 1'b1; in_wr = 1'b0; in_ts_valid = 1'b0; in_data = '0; in_ctrl = '0;
    in_ts = '0; out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    // Reset state, observed while reset is still held.
    chk("rst_out0", {out_ctrl0, out_data0}, 72'd0);
    chk("rst_out1", {out_ctrl1, out_data1}, 72'd0);
    chk("rst_flags0", 72'({st0, ovf0, out_wr0, in_rdy0}), 72'({32'd0, 1'b0, 1'b0, 1'b1}));
    chk("rst_flags1", 72'({st1, ovf1, out_wr1, in_rdy1}), 72'({32'd0, 1'b0, 1'b0, 1'b1}));
    reset = 1'b0;

    // Single stamped packet.
    push_ts(64'h0000_0001_0000_00AB);
    send_pkt(3, 8'h01, 64'h1000);
    end_burst();
    wait_cycles(10);
    pos = 0;
    chk_pkt("t1", 0, pos, 1'b1, 64'h0000_0001_0000_00AB, 3, 8'h01, 64'h1000);
    chk("t1_count", 72'(q0.size()), 72'd6);
    chk("t1_lat", 72'(first_cyc(0)), 72'(sop_cyc + 2));
    chk("t1_stamped0", 72'(st0), 72'd1);
    chk("t1_stamped1", 72'(st1), 72'd1);

    // Missing stamp: pass-through vs zero stamp.
    do_reset();
    send_pkt(1, 8'h02, 64'h2000);
    end_burst();
    wait_cycles(10);
    pos = 0;
    chk_pkt("t2a", 0, pos, 1'b0, 64'h0, 1, 8'h02, 64'h2000);
    chk("t2a_count", 72'(q0.size()), 72'd3);
    chk("t2a_lat", 72'(first_cyc(0)), 72'(sop_cyc + 3));
    chk("t2a_stamped", 72'(st0), 72'd0);
    pos = 0;
    chk_pkt("t2b", 1, pos, 1'b1, 64'h0, 1, 8'h02, 64'h2000);
    chk("t2b_count", 72'(q1.size()), 72'd4);
    chk("t2b_lat", 72'(first_cyc(1)), 72'(sop_cyc + 2));
    chk("t2b_stamped", 72'(st1), 72'd1);

    // Backpressure: out_rdy toggles every cycle over a 10-word packet.
    do_reset();
    saw_full = 1'b0;
    push_ts(64'h55);
    toggle_en = 1'b1;
    send_pkt(8, 8'h03, 64'h3000);
    end_burst();
    wait_cycles(40);
    toggle_en = 1'b0;
    out_rdy = 1'b1;
    wait_cycles(5);
    pos = 0;
    chk_pkt("t3", 0, pos, 1'b1, 64'h55, 8, 8'h03, 64'h3000);
    chk("t3_count", 72'(q0.size()), 72'd11);
    chk("t3_in_rdy_low", 72'(saw_full), 72'd1);
    chk("t3_stamped", 72'(st0), 72'd1);

    // Back-to-back packets with three queued stamps.
    do_reset();
    push_ts(64'h10); push_ts(64'h20); push_ts(64'h30);
    send_pkt(1, 8'h01, 64'h4000);
    send_pkt(1, 8'h01, 64'h4100);
    send_pkt(1, 8'h01, 64'h4200);
    end_burst();
    wait_cycles(15);
    pos = 0;
    chk_pkt("t4p0", 0, pos, 1'b1, 64'h10, 1, 8'h01, 64'h4000);
    chk_pkt("t4p1", 0, pos, 1'b1, 64'h20, 1, 8'h01, 64'h4100);
    chk_pkt("t4p2", 0, pos, 1'b1, 64'h30, 1, 8'h01, 64'h4200);
    chk("t4_count", 72'(q0.size()), 72'd12);
    chk("t4_stamped", 72'(st0), 72'd3);

    // TS FIFO overflow: 9 stamps into an 8-deep FIFO.
    do_reset();
    for (int i = 0; i < 8; i++) push_ts(64'h100 + 64'(i));
    chk("t5_ovf_before", 72'(ovf0), 72'd0);
    push_ts(64'h108);
    chk("t5_ovf0", 72'(ovf0), 72'd1);
    chk("t5_ovf1", 72'(ovf1), 72'd1);
    for (int p = 0; p < 9; p++) send_pkt(1, 8'h01, 64'h5000 + 64'(p * 256));
    end_burst();
    wait_cycles(20);
    pos = 0;
    for (int p = 0; p < 8; p++)
      chk_pkt($sformatf("t5p%0d", p), 0, pos, 1'b1, 64'h100 + 64'(p), 1, 8'h01,
              64'h5000 + 64'(p * 256));
    chk_pkt("t5p8", 0, pos, 1'b0, 64'h0, 1, 8'h01, 64'h5800);
    chk("t5_count", 72'(q0.size()), 72'd35);
    chk("t5_stamped0", 72'(st0), 72'd8);
    chk("t5_ovf_sticky", 72'(ovf0), 72'd1);
    chk("t5_count1", 72'(q1.size()), 72'd36);
    chk("t5_stamped1", 72'(st1), 72'd9);

    // Reset in the middle of a packet.
    do_reset();
    push_ts(64'hA1);
    send_word(8'hFF, 64'h6000);
    send_word(8'h00, 64'h6001);
    send_word(8'h00, 64'h6002);
    @(negedge clk); in_wr = 1'b0;
    g = 0;
    while (q0.size() < 2 && g < 50) begin @(negedge clk); #1; g++; end
    chk("t6_fwd_timeout", 72'(g >= 50), 72'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_out_wr", 72'(out_wr0), 72'd0);
    chk("t6_rst_stamped", 72'(st0), 72'd0);
    reset = 1'b0;
    q0.delete(); q1.delete(); qc0.delete(); qc1.delete();
    push_ts(64'hB2);
    send_pkt(2, 8'h04, 64'h7000);
    end_burst();
    wait_cycles(10);
    pos = 0;
    chk_pkt("t6", 0, pos, 1'b1, 64'hB2, 2, 8'h04, 64'h7000);
    chk("t6_count", 72'(q0.size()), 72'd5);
    chk("t6_stamped", 72'(st0), 72'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/timestamp_hdr_insert.md
Name: timestamp_hdr_insert

Overview:
- Sits directly downstream of the timestamping input arbiter, between it and the output port lookup stage.
- Consumes the arbitrated packet stream and its per-packet 64-bit timestamp.
- Prepends the timestamp to each packet as one extra module-header word, so later stages and the host see arrival time in-band.
- Packets arriving with no timestamp are passed through unchanged, or stamped with zero, depending on a parameter.

Parameters:
DATA_WIDTH, 64, datapath width; must be 64.
CTRL_WIDTH, DATA_WIDTH/8, control width.
TS_CTRL, 8'hEE, ctrl value placed on the inserted timestamp word.
TS_FIFO_DEPTH_BITS, 3, log2 depth of the pending-timestamp FIFO.
STAMP_MISSING, 0, 1 = insert an all-zero timestamp word when none is pending; 0 = pass the packet unmodified.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
in_data  in  64  packet word from arbiter.
in_ctrl  in  8  packet ctrl from arbiter.
in_wr  in  1  word valid.
in_rdy  out  1  may accept words; = !input_fifo.nearly_full.
in_timestamp  in  64  packet arrival time.
in_timestamp_valid  in  1  one-cycle pulse; pushes in_timestamp.
out_data  out  64  word to next stage.
out_ctrl  out  8  ctrl to next stage.
out_wr  out  1  word valid.
out_rdy  in  1  downstream can accept.
stamped_pkts  out  32  count of packets that received a timestamp word, wrapping.
ts_overflow  out  1  sticky; set when a timestamp is dropped on a full TS FIFO.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: out_wr=0, out_ctrl=0, out_data=0, stamped_pkts=0, ts_overflow=0, state=IDLE. Both FIFOs are emptied.
- Reset mid-packet: the partial packet is discarded. The first word written after reset is treated as start of packet (SOP).
- Buffering:
  - Word FIFO: small_fifo, width 72, depth 4, written by in_wr.
  - TS FIFO: small_fifo, width 64, depth 2^TS_FIFO_DEPTH_BITS, written by in_timestamp_valid.
  - Push to a full TS FIFO: the push is ignored and ts_overflow is set to 1.
- Packet framing:
  - Leading words with ctrl!=0 are module headers.
  - Words with ctrl==0 are payload.
  - The first ctrl!=0 word after at least one payload word is EOP.
- Output: a registered stage. A word is popped and out_wr_next=1 only in a cycle where out_rdy=1 and the source is non-empty. When out_rdy=0, nothing is popped and out_wr=0 next cycle.
- States:
  - IDLE:
    - Waits for the word FIFO to be non-empty and out_rdy=1.
    - If the TS FIFO is non-empty: emit {TS_CTRL, ts_fifo head}, pop the TS FIFO, increment stamped_pkts, go to HDR. The packet word is not popped.
    - Else if STAMP_MISSING=1: emit {TS_CTRL, 64'h0}, increment stamped_pkts, go to HDR.
    - Else: go to HDR directly with no output that cycle.
  - HDR:
    - Pops and forwards words.
    - Forwarding a ctrl==0 word moves to PAYLOAD.
  - PAYLOAD:
    - Pops and forwards words.
    - Forwarding a ctrl!=0 word is EOP and returns to IDLE.
- Simultaneous events: a TS push and a TS pop in the same cycle are both honoured. A push is ignored only when the FIFO is full and no pop occurs that cycle.
- Timestamp order: timestamps pair with packets in FIFO order. The arbiter pulses in_timestamp_valid at least one cycle before the first in_wr of the packet. A pulse coinciding with the first in_wr is also valid.
- Latency:
  - Stamped packet: first out_wr (the TS word) is 2 cycles after the first in_wr with out_rdy held high. The packet data follows back-to-back.
  - Unstamped packet: 3 cycles (the IDLE→HDR transition costs one cycle).
  - Each packet costs one extra cycle per SOP.
- Counter: stamped_pkts wraps 0xFFFFFFFF → 0.

Test Plan:
- Single packet, stamp valid: TS pulse 0x0000_0001_0000_00AB, then header(ctrl=0xFF), 3 payload words (ctrl=0), EOP(ctrl=0x01) with out_rdy=1 -> output is 6 words: ctrl 0xEE / data 0x0000_0001_0000_00AB first, then the 5 words unchanged; stamped_pkts=1.
- Missing stamp, STAMP_MISSING=0: packet with no pulse -> forwarded unmodified, stamped_pkts stays 0. Repeat with STAMP_MISSING=1 -> zero-data 0xEE word prepended, stamped_pkts=1.
- Backpressure: toggle out_rdy every cycle during a 10-word packet -> no word lost or duplicated, out_wr never 1 in the cycle after out_rdy=0 was sampled, in_rdy deasserts when the word FIFO nearly fills.
- Back-to-back packets: 3 stamps queued (0x10, 0x20, 0x30) then 3 packets -> each packet carries its stamp in order, stamped_pkts=3.
- TS overflow (TS_FIFO_DEPTH_BITS=3): push 9 stamps with no packets -> ts_overflow=1; the first 8 stamps are later emitted in order and the 9th is never emitted.
- Reset mid-packet: assert reset after 2 words forwarded -> the next cycle shows out_wr=0 and stamped_pkts=0; the next packet is correctly delimited and stamped.
